demux_dispatch_ctrl: RTL and testbench
======================================

Name: demux_dispatch_ctrl

Overview:
Sequencing controller for the 1-to-8 demultiplexer datapath. Accepts items on a single valid/ready input stream, holds each in a one-entry register and dispatches it to one of 8 output channels with per-channel valid/ready handshakes. The destination is either addressed by the producer or chosen round-robin. Drives the demux select and the shared output data bus.

Parameters:
DATA_W, 8, width of the dispatched data item.
TIMEOUT, 16, round-robin-mode cycles to wait on a stalled channel before skipping it; 0 disables skipping.
CNT_W, 16, width of the dispatch counter.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
mode  input  1  0 = addressed (use in_dest), 1 = round-robin
in_valid  input  1  input item present
in_data  input  DATA_W  input item
in_dest  input  3  destination channel in addressed mode
in_ready  output  1  controller can accept an item this cycle
out_valid  output  8  one-hot valid to the selected channel
out_ready  input  8  per-channel ready
out_data  output  DATA_W  shared data bus to all channels (held item)
sel  output  3  demux select = current target channel
busy  output  1  item held (state SEND)
dispatch_cnt  output  CNT_W  completed dispatches, wraps modulo 2^CNT_W

Behaviour:
- One clock, clk. Reset asynchronous, active-high, on rst.
- Reset values: state=IDLE, out_valid=0, out_data=0, sel=0, rr_ptr=0, wait_cnt=0, dispatch_cnt=0, busy=0, held mode=0.
- States: IDLE (no item held), SEND (item held, out_valid asserted).
- in_ready (combinational) = (state==IDLE) | (state==SEND & out_ready[sel]).
- Input accept = in_valid & in_ready. On accept, the following are registered at the clock edge:
  - out_data <= in_data; held mode <= mode.
  - sel <= mode ? rr_ptr : in_dest (rr_ptr is the value after any same-cycle advance).
  - wait_cnt <= 0; state <= SEND.
- mode is sampled only at accept. Changes while in SEND do not affect the held item.
- SEND: out_valid = one-hot(sel); all other bits are 0. out_valid is 0 in IDLE.
- Dispatch = state==SEND & out_ready[sel]. On dispatch:
  - dispatch_cnt increments.
  - If held mode is round-robin, rr_ptr <= sel+1 mod 8 (7 wraps to 0).
  - If there is no same-cycle accept, state <= IDLE.
- Back-to-back: dispatch and accept in the same cycle → stay in SEND with the new item. Sustained throughput is 1 item per cycle.
- Latency: an item accepted at edge N is presented (out_valid high) in the cycle after edge N. Minimum accept-to-dispatch is 1 cycle.
- Stall, addressed mode: wait indefinitely with no skip. wait_cnt is held at 0.
- Stall, round-robin mode with TIMEOUT>0: wait_cnt increments each SEND cycle without a dispatch.
  - When wait_cnt==TIMEOUT-1 and no dispatch: sel <= sel+1 mod 8, rr_ptr <= sel+1 mod 8, wait_cnt <= 0.
  - The data is retained and is never dropped.
- out_ready bits of unselected channels are ignored.
- in_dest is ignored in round-robin mode.
- Reset mid-SEND: the held item is discarded and all outputs take their reset values immediately (asynchronous).
- dispatch_cnt wraps from 2^CNT_W-1 to 0 silently.

Decomposition:
- Shared package demux_pkg: NUM_CH=8, SEL_W=3, state encoding constants (ST_IDLE=0, ST_SEND=1), MODE_ADDR=0, MODE_RR=1.
- One natural sub-module: dispatch_wait_timer (wait_cnt, clear/enable inputs, expire output at TIMEOUT-1, disabled when TIMEOUT==0).

Test Plan:
- Reset release, all out_ready=1, mode=0, stream dest 3,5,0 with data A1,B2,C3 back-to-back:
  - out_valid=8'h08/8'h20/8'h01 on consecutive cycles, each carrying the matching data.
  - dispatch_cnt=3; in_ready stays 1 throughout.
- mode=1, all ready, 10 items:
  - sel sequence 0,1,…,7,0,1 and rr_ptr=2 at the end.
- mode=1, TIMEOUT=4, out_ready[2]=0, item held at sel=2:
  - After 4 stalled cycles sel becomes 3 with the same out_data, dispatched on ch3.
  - dispatch_cnt increments by 1 only.
- mode=0, dest 6, out_ready[6]=0 for 50 cycles:
  - out_valid=8'h40 held, in_ready=0, no skip.
  - Raising ready[6] gives a dispatch within that cycle.
- Assert rst while busy in SEND:
  - out_valid=0, busy=0, sel=0, dispatch_cnt=0 immediately, before the next clock edge.
- CNT_W=4, 17 dispatches:
  - dispatch_cnt reads 1 (wrap verified).

Source files
------------

// File: rtl/demux_pkg.sv
// Shared definitions for the 1-to-8 demux dispatch controller.
package demux_pkg;

    localparam int NUM_CH = 8;
    localparam int SEL_W  = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

    localparam logic MODE_ADDR = 1'b0;
    localparam logic MODE_RR   = 1'b1;

    function automatic logic [NUM_CH-1:0] onehot_sel(input logic [SEL_W-1:0] s);
        return {{(NUM_CH-1){1'b0}}, 1'b1} << s;
    endfunction

endpackage

// File: rtl/dispatch_wait_timer.sv
// Counts stalled round-robin cycles; expire pulses on the last tolerated cycle.
module dispatch_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int          CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic        ENABLED = (TIMEOUT > 0);
    // Truncation for TIMEOUT==0 is harmless: expire is gated by ENABLED.
    localparam logic [CW-1:0] LAST  = CW'(TIMEOUT - 1);

    logic [CW-1:0] wait_cnt_q;
    logic [CW-1:0] wait_cnt_d;

    assign expire = ENABLED & en & (wait_cnt_q == LAST);

    // Next wait count: restart on clear or expiry, advance while stalled.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (clr || expire) begin
            wait_cnt_d = {CW{1'b0}};
        end else if (en && ENABLED) begin
            wait_cnt_d = wait_cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            wait_cnt_d = wait_cnt_q;
        end
    end

    // Wait count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_q <= {CW{1'b0}};
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

endmodule

// File: rtl/demux_dispatch_ctrl.sv
// One-entry dispatch controller steering items to 8 channels, addressed or round-robin,
// with skip-on-stall in round-robin mode.
module demux_dispatch_ctrl
    import demux_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic [SEL_W-1:0]  in_dest,
    output logic              in_ready,
    output logic [NUM_CH-1:0] out_valid,
    input  logic [NUM_CH-1:0] out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [SEL_W-1:0]  sel,
    output logic              busy,
    output logic [CNT_W-1:0]  dispatch_cnt
);

    state_e            state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [SEL_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              mode_q, mode_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              dispatch_s;
    logic              accept_s;
    logic              stall_rr_s;
    logic              expire_s;
    logic [SEL_W-1:0]  sel_inc_s;

    assign dispatch_s = (state_q == ST_SEND) & out_ready[sel_q];
    assign in_ready   = (state_q == ST_IDLE) | dispatch_s;
    assign accept_s   = in_valid & in_ready;
    assign sel_inc_s  = sel_q + 3'd1;
    assign stall_rr_s = (state_q == ST_SEND) & (mode_q == MODE_RR) & ~dispatch_s;

    // Any cycle that is not a round-robin stall keeps the timer at zero.
    dispatch_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (~stall_rr_s),
        .en     (stall_rr_s),
        .expire (expire_s)
    );

    // Next-state: dispatch/skip first, then a same-cycle accept overrides the slot.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        rr_ptr_d = rr_ptr_q;
        data_d   = data_q;
        mode_d   = mode_q;
        cnt_d    = cnt_q;
        if (dispatch_s) begin
            cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            state_d = ST_IDLE;
            if (mode_q == MODE_RR) begin
                rr_ptr_d = sel_inc_s;
            end else begin
                rr_ptr_d = rr_ptr_q;
            end
        end else if (expire_s) begin
            sel_d    = sel_inc_s;
            rr_ptr_d = sel_inc_s;
        end else begin
            state_d = state_q;
        end
        if (accept_s) begin
            data_d  = in_data;
            mode_d  = mode;
            sel_d   = (mode == MODE_RR) ? rr_ptr_d : in_dest;
            state_d = ST_SEND;
        end else begin
            mode_d = mode_q;
        end
    end

    // Controller state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            sel_q    <= {SEL_W{1'b0}};
            rr_ptr_q <= {SEL_W{1'b0}};
            data_q   <= {DATA_W{1'b0}};
            mode_q   <= MODE_ADDR;
            cnt_q    <= {CNT_W{1'b0}};
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            rr_ptr_q <= rr_ptr_d;
            data_q   <= data_d;
            mode_q   <= mode_d;
            cnt_q    <= cnt_d;
        end
    end

    assign out_valid    = (state_q == ST_SEND) ? onehot_sel(sel_q) : {NUM_CH{1'b0}};
    assign out_data     = data_q;
    assign sel          = sel_q;
    assign busy         = (state_q == ST_SEND);
    assign dispatch_cnt = cnt_q;

endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
// Directed bench for demux_dispatch_ctrl built with TIMEOUT=4 and CNT_W=4.
module tb_demux_dispatch_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       mode;
    logic       in_valid;
    logic [7:0] in_data;
    logic [2:0] in_dest;
    logic       in_ready;
    logic [7:0] out_valid;
    logic [7:0] out_ready;
    logic [7:0] out_data;
    logic [2:0] sel;
    logic       busy;
    logic [3:0] dispatch_cnt;

    int vectors = 0;
    int fails   = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    demux_dispatch_ctrl #(
        .DATA_W  (8),
        .TIMEOUT (4),
        .CNT_W   (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mode         (mode),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_dest      (in_dest),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .sel          (sel),
        .busy         (busy),
        .dispatch_cnt (dispatch_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        rst       = 1'b1;
        mode      = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_dest   = 3'd0;
        out_ready = 8'hFF;
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_sel", 32'(sel), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_cnt", 32'(dispatch_cnt), 32'h0);
        chk("rst_out_data", 32'(out_data), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        tick();
        tick();
        rst = 1'b0;

        // Addressed mode, back-to-back to 3, 5, 0.
        in_valid = 1'b1; in_data = 8'hA1; in_dest = 3'd3;
        #1;
        chk("addr_in_ready0", 32'(in_ready), 32'h1);
        tick();
        chk("addr_ov_a1", 32'(out_valid), 32'h08);
        chk("addr_data_a1", 32'(out_data), 32'hA1);
        chk("addr_in_ready1", 32'(in_ready), 32'h1);
        in_data = 8'hB2; in_dest = 3'd5;
        tick();
        chk("addr_ov_b2", 32'(out_valid), 32'h20);
        chk("addr_data_b2", 32'(out_data), 32'hB2);
        chk("addr_in_ready2", 32'(in_ready), 32'h1);
        chk("addr_cnt1", 32'(dispatch_cnt), 32'h1);
        in_data = 8'hC3; in_dest = 3'd0;
        tick();
        chk("addr_ov_c3", 32'(out_valid), 32'h01);
        chk("addr_data_c3", 32'(out_data), 32'hC3);
        chk("addr_cnt2", 32'(dispatch_cnt), 32'h2);
        in_valid = 1'b0;
        tick();
        exp_cnt = 3;
        chk("addr_cnt3", 32'(dispatch_cnt), 32'h3);
        chk("addr_idle_ov", 32'(out_valid), 32'h0);
        chk("addr_idle_busy", 32'(busy), 32'h0);

        // Round-robin, all ready: 10 items land on 0..7,0,1.
        mode = 1'b1; in_valid = 1'b1; in_dest = 3'd5;
        for (int i = 0; i < 10; i++) begin
            in_data = 8'(8'h10 + i);
            tick();
            if (i > 0) exp_cnt++;
            chk("rr_sel", 32'(sel), 32'(i % 8));
            chk("rr_ov", 32'(out_valid), 32'(1) << (i % 8));
            chk("rr_data", 32'(out_data), 32'(8'h10 + i));
        end
        in_data = 8'h1A;
        tick();
        exp_cnt++;
        chk("rr_ptr_after10", 32'(sel), 32'h2);
        chk("rr_cnt10", 32'(dispatch_cnt), 32'(exp_cnt % 16));
        // Walk the pointer round to 2 again.
        for (int k = 0; k < 7; k++) begin
            in_data = 8'(8'h20 + k);
            tick();
            exp_cnt++;
            chk("rr_walk_sel", 32'(sel), 32'((3 + k) % 8));
        end
        in_valid = 1'b0;
        tick();
        exp_cnt++;
        chk("rr_walk_busy", 32'(busy), 32'h0);
        chk("rr_walk_cnt", 32'(dispatch_cnt), 32'(exp_cnt % 16));

        // Round-robin stall on channel 2: skip to 3 after 4 stalled cycles.
        out_ready = 8'hFB; in_valid = 1'b1; in_data = 8'h5A; in_dest = 3'd7;
        tick();
        in_valid = 1'b0;
        mode = 1'b0;
        #1;
        chk("to_sel2", 32'(sel), 32'h2);
        chk("to_ov2", 32'(out_valid), 32'h04);
        chk("to_in_ready", 32'(in_ready), 32'h0);
        for (int s = 0; s < 3; s++) begin
            tick();
            chk("to_hold_sel", 32'(sel), 32'h2);
            chk("to_hold_data", 32'(out_data), 32'h5A);
        end
        tick();
        chk("to_skip_sel", 32'(sel), 32'h3);
        chk("to_skip_ov", 32'(out_valid), 32'h08);
        chk("to_skip_data", 32'(out_data), 32'h5A);
        chk("to_skip_ready", 32'(in_ready), 32'h1);
        chk("to_skip_cnt", 32'(dispatch_cnt), 32'(exp_cnt % 16));
        tick();
        exp_cnt++;
        chk("to_done_busy", 32'(busy), 32'h0);
        chk("to_done_cnt", 32'(dispatch_cnt), 32'(exp_cnt % 16));

        // Addressed stall on channel 6: no skip, ever.
        out_ready = 8'hBF; in_valid = 1'b1; in_data = 8'h66; in_dest = 3'd6;
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < 50; c++) begin
            chk("st_ov", 32'(out_valid), 32'h40);
            chk("st_in_ready", 32'(in_ready), 32'h0);
            tick();
        end
        chk("st_data", 32'(out_data), 32'h66);
        out_ready = 8'hFF;
        #1;
        chk("st_release_ready", 32'(in_ready), 32'h1);
        tick();
        exp_cnt++;
        chk("st_done_busy", 32'(busy), 32'h0);
        chk("st_done_cnt", 32'(dispatch_cnt), 32'(exp_cnt % 16));

        // Asynchronous reset while an item is held.
        out_ready = 8'h00; in_valid = 1'b1; in_data = 8'h77; in_dest = 3'd4;
        tick();
        in_valid = 1'b0;
        chk("ar_busy_pre", 32'(busy), 32'h1);
        chk("ar_ov_pre", 32'(out_valid), 32'h10);
        #1;
        rst = 1'b1;
        #1;
        chk("ar_ov", 32'(out_valid), 32'h0);
        chk("ar_busy", 32'(busy), 32'h0);
        chk("ar_sel", 32'(sel), 32'h0);
        chk("ar_cnt", 32'(dispatch_cnt), 32'h0);
        chk("ar_data", 32'(out_data), 32'h0);
        tick();
        rst = 1'b0;
        exp_cnt = 0;

        // 17 dispatches wrap a 4-bit counter to 1.
        out_ready = 8'hFF; mode = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            in_data = 8'(i);
            in_dest = 3'(i % 8);
            tick();
        end
        in_valid = 1'b0;
        tick();
        chk("wrap_cnt", 32'(dispatch_cnt), 32'h1);
        chk("wrap_busy", 32'(busy), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
